dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port, word-addressed data memory between two requesters.
//  Port 0 is the core load/store unit; port 1 is the DMA/debug master.
//  Round-robin arbitration, optional lock for atomic read-modify-write,
//  alignment/range checking, and a registered response per port.
// PARAMETERS
//  ADDR_W       8    word-index bits; memory holds 2**ADDR_W words, byte address bits [ADDR_W+1:2]
//  RR_EN        1    1 = round-robin; 0 = fixed priority, port 0 always wins
//  LOCK_TIMEOUT 16   idle cycles a lock owner may hold the lock without requesting
// PORTS
//  CLK      in  1   clock, all state updates on posedge
//  RST_N    in  1   asynchronous active-low reset
//  REQi     in  1   port i request, held until GNTi (i = 0,1)
//  WEi      in  1   port i write enable
//  Ai       in  32  port i byte address
//  WDi      in  32  port i write data
//  LOCKi    in  1   port i keeps ownership after this access
//  GNTi     out 1   port i accepted this cycle (combinational)
//  RVALIDi  out 1   port i response valid, one-cycle pulse
//  RERRi    out 1   port i access rejected (misaligned or out of range), valid with RVALIDi
//  RDATAi   out 32  port i read data, valid with RVALIDi
//  MEM_A    out 32  memory byte address
//  MEM_WD   out 32  memory write data
//  MEM_WE   out 1   memory write enable, sampled by memory at posedge
//  MEM_RD   in  32  memory combinational read data
//  LOCK_TO  out 1   sticky flag: a lock was force-released by timeout
// BEHAVIOUR
//  Reset values
//   - State = IDLE, LAST = 1 (port 0 wins the first conflict), timeout counter = 0.
//   - RVALIDi = 0, RERRi = 0, RDATAi = 0, LOCK_TO = 0.
//   - Reset mid-operation aborts any lock and drops any pending response.
//  Grant
//   - At most one GNTi per cycle. Granting is combinational from REQ, state and LAST.
//   - The memory access occurs in the grant cycle: MEM_A/MEM_WD/MEM_WE = granted port's A/WD/WE.
//  Memory outputs with no grant
//   - MEM_WE = 0, MEM_A = 0, MEM_WD = 0.
//  Arbitration in IDLE
//   - Single requester: that requester is granted.
//   - Both requesting, RR_EN=1: the port not in LAST is granted.
//   - Both requesting, RR_EN=0: port 0 is granted.
//   - LAST updates to the granted port on every grant.
//  Response
//   - At the posedge ending the grant cycle: RDATAi <= MEM_RD and RVALIDi <= 1 for one cycle.
//   - Writes also return RVALIDi (acknowledge); RDATAi then holds the pre-write word.
//   - Back-to-back grants give back-to-back RVALIDs.
//   - A requester may raise a new REQ in the same cycle its RVALID is high.
//  Error
//   - Condition: Ai[1:0] != 0 or Ai[31:ADDR_W+2] != 0.
//   - The access is still granted, with MEM_WE forced to 0.
//   - Next cycle: RVALIDi = 1, RERRi = 1, RDATAi = 0.
//   - An errored access never changes the lock state.
//  FSM states: IDLE, LOCK0, LOCK1
//   - IDLE -> LOCKi: grant to port i with LOCKi = 1 and no error.
//   - LOCKi: only port i may be granted; the other port waits with GNT = 0.
//   - LOCKi -> IDLE: a port i grant with LOCKi = 0; that access completes normally.
//   - Timeout counter: cleared on each port i grant; increments each LOCKi cycle with REQi = 0.
//   - Counter reaching LOCK_TIMEOUT: -> IDLE, set LOCK_TO, counter cleared.
//   - In the release cycle, arbitration is still restricted to port i. The other port is eligible from the next cycle.
//   - LOCK_TO clears only on reset.
// TESTING
//  1. Write via port 0: REQ0 WE0 A0=0x10 WD0=0xDEADBEEF; then read A0=0x10
//     -> GNT0 both times, RVALID0 next cycle each, RDATA0=0xDEADBEEF on the read.
//  2. REQ0 and REQ1 held high for 4 cycles from reset
//     -> grants alternate 0,1,0,1; RVALIDs follow the same order one cycle later.
//  3. RR_EN=0, both requesting 3 cycles -> GNT0 every cycle, GNT1 never.
//  4. Port 1 locked read of A1=0x20, then locked-release write A1=0x20 WD1=0x5, with REQ0 held high
//     -> GNT0 = 0 until the cycle after the release; port 0 then reads 0x5.
//  5. A0=0x13 write, then A0=0x400 read (ADDR_W=8)
//     -> RERR0=1, RDATA0=0, MEM_WE stays 0; memory word 4 unchanged.
//  6. Port 0 locks, then REQ0=0 for 16 cycles while REQ1=1
//     -> LOCK_TO=1, GNT1 in the following cycle; assert RST_N=0 mid-lock -> IDLE, all outputs 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, word-addressed data memory between the
// core load/store unit (port 0) and the DMA/debug master (port 1).
// Arbitration is round-robin or fixed priority. An owner may hold the memory
// across accesses for atomic read-modify-write, and a lock that goes unused
// for too long is taken back. Accesses are checked for alignment and range,
// and each port gets a registered response.
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   REQi/WEi/Ai/WDi/LOCKi    port i request, held until GNTi (i = 0,1)
//   GNTi                     port i accepted this cycle (combinational)
//   RVALIDi/RERRi/RDATAi     port i registered response, one-cycle pulse
//   MEM_A/MEM_WD/MEM_WE      memory access of the granted port (combinational)
//   MEM_RD                   memory combinational read data
//   LOCK_TO                  sticky: a lock was force-released by timeout
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter bit          RR_EN        = 1'b1,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ0,
  input  logic        WE0,
  input  logic [31:0] A0,
  input  logic [31:0] WD0,
  input  logic        LOCK0,
  input  logic        REQ1,
  input  logic        WE1,
  input  logic [31:0] A1,
  input  logic [31:0] WD1,
  input  logic        LOCK1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        RVALID0,
  output logic        RVALID1,
  output logic        RERR0,
  output logic        RERR1,
  output logic [31:0] RDATA0,
  output logic [31:0] RDATA1,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_WD,
  output logic        MEM_WE,
  input  logic [31:0] MEM_RD,
  output logic        LOCK_TO
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q;
  logic               lock_to_q, lock_to_set;
  logic               gnt0, gnt1;
  logic               err0, err1;
  logic               rvalid0_q, rvalid1_q, rerr0_q, rerr1_q;
  logic [31:0]        rdata0_q, rdata1_q;

  // Misaligned or beyond the last memory word.
  function automatic logic addr_bad(input logic [31:0] a);
    addr_bad = (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  assign err0 = addr_bad(A0);
  assign err1 = addr_bad(A1);

  // State register and lock timeout bookkeeping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      lock_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt1)      last_q <= 1'b1;
      else if (gnt0) last_q <= 1'b0;
      if (lock_to_set) lock_to_q <= 1'b1;
    end
  end

  // Next state: lock entry/release and idle-owner timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_to_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // An errored access never takes the lock.
        if (gnt0 && LOCK0 && !err0)      state_d = ST_LOCK0;
        else if (gnt1 && LOCK1 && !err1) state_d = ST_LOCK1;
      end
      ST_LOCK0: begin
        if (gnt0) begin
          cnt_d = '0;
          if (!LOCK0 && !err0) state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          lock_to_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCK1: begin
        if (gnt1) begin
          cnt_d = '0;
          if (!LOCK1 && !err1) state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          lock_to_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant and memory mux; a locked owner excludes the other port,
  // including in its release cycle.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    MEM_A  = '0;
    MEM_WD = '0;
    MEM_WE = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ0 && REQ1) begin
          if (RR_EN && !last_q) gnt1 = 1'b1;
          else                  gnt0 = 1'b1;
        end else begin
          gnt0 = REQ0;
          gnt1 = REQ1;
        end
      end
      ST_LOCK0: gnt0 = REQ0;
      ST_LOCK1: gnt1 = REQ1;
      default: ;
    endcase
    if (gnt0) begin
      MEM_A  = A0;
      MEM_WD = WD0;
      MEM_WE = WE0 && !err0;
    end else if (gnt1) begin
      MEM_A  = A1;
      MEM_WD = WD1;
      MEM_WE = WE1 && !err1;
    end
  end

  // Registered per-port responses; writes return the pre-write word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rerr0_q   <= 1'b0;
      rerr1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      rerr0_q   <= gnt0 && err0;
      rerr1_q   <= gnt1 && err1;
      rdata0_q  <= (gnt0 && !err0) ? MEM_RD : 32'd0;
      rdata1_q  <= (gnt1 && !err1) ? MEM_RD : 32'd0;
    end
  end

  assign GNT0    = gnt0;
  assign GNT1    = gnt1;
  assign RVALID0 = rvalid0_q;
  assign RVALID1 = rvalid1_q;
  assign RERR0   = rerr0_q;
  assign RERR1   = rerr1_q;
  assign RDATA0  = rdata0_q;
  assign RDATA1  = rdata1_q;
  assign LOCK_TO = lock_to_q;

endmodule
